// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core and its program feeder: opcode
// nibbles that carry an operand byte, the idle byte and the feeder states.
package cpu_pkg;

    localparam logic [3:0] OP_STI = 4'b1000;   // store immediate
    localparam logic [3:0] OP_INA = 4'b0110;   // input A
    localparam logic [3:0] OP_INB = 4'b0111;   // input B

    // The core treats this byte as its default / no-op.
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_OPND
    } state_t;

    // True when the opcode in this byte is followed by an operand byte.
    function automatic logic is_two_byte(input logic [7:0] op_byte);
        return (op_byte[7:4] == OP_STI) ||
               (op_byte[7:4] == OP_INA) ||
               (op_byte[7:4] == OP_INB);
    endfunction

endpackage

// File: rtl/cpu_prog_mem.sv
// Program memory: DEPTH x 8 register file, synchronous write, combinational read.
module cpu_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];

    // Host write port.
    // NOTE: the array has no reset; the program survives a reset and a reset
    // network on every bit would only cost area.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/cpu_prog_feeder.sv
// Program feeder for the 8-bit cpu core: holds a small host-loaded program
// and streams it onto the core's input bus one byte per clock, with run,
// single-instruction step and stop. Operand bytes always follow their opcode
// on the very next cycle.
module cpu_prog_feeder
    import cpu_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active low
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          step,
    input  logic          stop,
    output logic [7:0]    cpu_in,
    output logic [AW:0]   pc,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t      r_state;
    state_t      r_ret;          // state to resume after an operand byte
    logic [AW:0] r_pc;
    logic [AW:0] r_len;
    logic [7:0]  r_cpu_in;
    logic        r_done;
    logic        r_err;
    logic        r_stop_pend;    // stop seen mid-instruction, honoured at its end

    state_t      w_state_nxt;
    state_t      w_ret_nxt;
    logic [AW:0] w_pc_nxt;
    logic [AW:0] w_len_nxt;
    logic [AW:0] w_pc_inc;
    logic [7:0]  w_cpu_in_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_stop_nxt;
    logic [7:0]  w_rd_data;
    logic        w_mem_we;

    // Host writes land only while idle so a running program never changes under us.
    assign w_mem_we = wr_en && (r_state == ST_IDLE);
    assign w_pc_inc = r_pc + 1'b1;

    cpu_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_pc[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: issued byte, pc, latched length and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ret       <= ST_IDLE;
            r_pc        <= '0;
            r_len       <= '0;
            r_cpu_in    <= IDLE_BYTE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_ret       <= w_ret_nxt;
            r_pc        <= w_pc_nxt;
            r_len       <= w_len_nxt;
            r_cpu_in    <= w_cpu_in_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_stop_pend <= w_stop_nxt;
        end
    end

    // Next-state and next-datapath logic.
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_ret_nxt    = r_ret;
        w_pc_nxt     = r_pc;
        w_len_nxt    = r_len;
        w_cpu_in_nxt = r_cpu_in;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        w_stop_nxt   = r_stop_pend;

        unique case (r_state)
            ST_IDLE: begin
                w_cpu_in_nxt = IDLE_BYTE;
                w_stop_nxt   = 1'b0;
                if (start) begin
                    w_len_nxt = prog_len;
                    w_pc_nxt  = '0;
                    w_err_nxt = 1'b0;
                    if (prog_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (step && (r_pc < prog_len)) begin
                    // Stepping samples the length too, so it works straight from reset.
                    w_len_nxt   = prog_len;
                    w_state_nxt = ST_STEP;
                end
            end

            ST_RUN: begin
                if (r_pc == r_len) begin
                    w_cpu_in_nxt = IDLE_BYTE;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else if (stop) begin
                    // At an instruction boundary here, so stop acts at once.
                    w_cpu_in_nxt = IDLE_BYTE;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cpu_in_nxt = w_rd_data;
                    w_pc_nxt     = w_pc_inc;
                    if (is_two_byte(w_rd_data)) begin
                        w_ret_nxt   = ST_RUN;
                        w_state_nxt = ST_OPND;
                    end
                end
            end

            ST_STEP: begin
                w_cpu_in_nxt = w_rd_data;
                w_pc_nxt     = w_pc_inc;
                if (is_two_byte(w_rd_data)) begin
                    w_ret_nxt   = ST_STEP;
                    w_state_nxt = ST_OPND;
                end else begin
                    w_done_nxt  = (w_pc_inc == r_len);
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_OPND: begin
                w_stop_nxt = r_stop_pend | stop;
                if (r_pc == r_len) begin
                    // Opcode was the last program byte: no operand to issue.
                    w_cpu_in_nxt = IDLE_BYTE;
                    w_err_nxt    = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_stop_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cpu_in_nxt = w_rd_data;
                    w_pc_nxt     = w_pc_inc;
                    if ((r_ret == ST_RUN) && !(r_stop_pend || stop)) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_done_nxt  = (r_ret == ST_STEP) && (w_pc_inc == r_len);
                        w_stop_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cpu_in = r_cpu_in;
    assign pc     = r_pc;
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign err    = r_err;

endmodule

// File: tb/tb_cpu_prog_feeder.sv
// Directed bench for cpu_prog_feeder: run, stop, step, truncated operand,
// zero-length run, write-while-busy and asynchronous reset.
module tb_cpu_prog_feeder;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          step = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    cpu_in;
    logic [AW:0]   pc;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_prog_feeder #(.DEPTH(16), .AW(AW), .IDLE_BYTE(8'hF0)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .prog_len (prog_len),
        .start    (start),
        .step     (step),
        .stop     (stop),
        .cpu_in   (cpu_in),
        .pc       (pc),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] prog[$]);
        foreach (prog[i]) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = prog[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_step;
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    // Bounded wait for the feeder to fall idle.
    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 40 && busy; k++) tick();
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] p1[$];
        logic [7:0] p3[$];
        logic [7:0] p4[$];
        p1 = '{8'h83, 8'h30, 8'h8F, 8'h44, 8'hC3};
        p3 = '{8'h60, 8'h00, 8'h10, 8'h20};
        p4 = '{8'h10, 8'h70};

        // Reset values.
        tick();
        tick();
        check("rst_cpu_in", cpu_in, 8'hF0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        tick();

        // Full run.
        load(p1);
        prog_len = 5'd5;
        pulse_start();
        check("t1_lat_cpu_in", cpu_in, 8'hF0);
        check("t1_lat_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t1_byte%0d", i), cpu_in, p1[i]);
            check($sformatf("t1_nodone%0d", i), done, 0);
        end
        tick();
        check("t1_end_cpu_in", cpu_in, 8'hF0);
        check("t1_done", done, 1);
        check("t1_pc", pc, 5);
        check("t1_err", err, 0);
        tick();
        check("t1_done_once", done, 0);
        check("t1_busy_end", busy, 0);

        // Stop while the first opcode's operand is pending.
        pulse_start();
        tick();
        check("t2_83", cpu_in, 8'h83);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t2_30", cpu_in, 8'h30);
        check("t2_pc", pc, 2);
        check("t2_nodone_a", done, 0);
        tick();
        check("t2_f0", cpu_in, 8'hF0);
        check("t2_nodone_b", done, 0);
        check("t2_busy", busy, 0);
        check("t2_pc_kept", pc, 2);
        pulse_start();
        tick();
        check("t2_restart", cpu_in, 8'h83);
        wait_idle("t2_finish");

        // Single-step walk.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        load(p3);
        prog_len = 5'd4;
        pulse_step();
        check("t3_s1_busy_a", busy, 1);
        tick();
        check("t3_s1_60", cpu_in, 8'h60);
        check("t3_s1_busy_b", busy, 1);
        tick();
        check("t3_s1_00", cpu_in, 8'h00);
        check("t3_s1_pc", pc, 2);
        check("t3_s1_idle", busy, 0);
        check("t3_s1_nodone", done, 0);
        pulse_step();
        tick();
        check("t3_s2_10", cpu_in, 8'h10);
        check("t3_s2_pc", pc, 3);
        check("t3_s2_nodone", done, 0);
        pulse_step();
        tick();
        check("t3_s3_20", cpu_in, 8'h20);
        check("t3_s3_done", done, 1);
        check("t3_s3_pc", pc, 4);
        pulse_step();
        check("t3_s4_busy", busy, 0);
        tick();
        check("t3_s4_cpu_in", cpu_in, 8'hF0);
        check("t3_s4_pc", pc, 4);

        // Two-byte opcode as the last byte.
        load(p4);
        prog_len = 5'd2;
        pulse_start();
        tick();
        check("t4_10", cpu_in, 8'h10);
        tick();
        check("t4_70", cpu_in, 8'h70);
        tick();
        check("t4_f0", cpu_in, 8'hF0);
        check("t4_err", err, 1);
        check("t4_done", done, 1);
        tick();
        check("t4_err_sticky", err, 1);

        // Zero-length start clears err and pulses done without running.
        prog_len = 5'd0;
        pulse_start();
        check("t5_err_clr", err, 0);
        check("t5_done", done, 1);
        check("t5_busy_a", busy, 0);
        check("t5_cpu_in", cpu_in, 8'hF0);
        tick();
        check("t5_done_once", done, 0);
        check("t5_busy_b", busy, 0);

        // Memory now holds 10,70,10,20,C3: write during RUN must be dropped.
        prog_len = 5'd5;
        pulse_start();
        tick();
        check("t6_first", cpu_in, 8'h10);
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        wait_idle("t6_finish");
        pulse_start();
        tick();
        check("t6_readback", cpu_in, 8'h10);
        tick();
        check("t6_opcode", cpu_in, 8'h70);
        // Asynchronous reset in the middle of the operand cycle.
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_cpu_in", cpu_in, 8'hF0);
        check("t6_rst_pc", pc, 0);
        check("t6_rst_busy", busy, 0);
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_stays", cpu_in, 8'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
